// File: rtl/pixel_rom8x16.sv
// 8x16 text-mode pixel serializer: counts down the font-ROM latency after each
// cell start, loads the glyph row into a shift register and emits one RGB pixel per strobe.
module pixel_rom8x16 #(
    parameter int         LAT      = 2,
    parameter logic [7:0] COLOR_FG = 8'hFF,
    parameter logic [7:0] COLOR_BG = 8'h00
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       pix_en,
    input  logic [9:0] Qh,
    input  logic [9:0] Qv,
    input  logic       video_on,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [7:0] DATO_ROM,
    output logic [7:0] RGB,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       err_sinc,
    output logic [1:0] estado_dbg
);

    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LAT = CW'(LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CUENTA = 2'd1;
    localparam logic [1:0] CARGA  = 2'd2;

    logic [1:0]    estado, estado_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    sr;
    logic          video_on_d;
    logic          inicio;
    logic          carga;
    logic          unused_ok;

    assign inicio     = pix_en && (Qh[2:0] == 3'b000);
    assign carga      = (estado == CARGA);
    assign estado_dbg = estado;
    // Only the column within the cell matters; the rest of the counters are ignored.
    assign unused_ok  = ^{Qv, Qh[9:3]};

    // CARGA is the last cycle of the countdown; SR loads on the edge that ends it.
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        case (estado)
            CUENTA: begin
                cnt_n = cnt - CNT_ONE;
                if (cnt_n == CNT_ONE) begin
                    estado_n = CARGA;
                end
            end
            CARGA: begin
                cnt_n    = '0;
                estado_n = IDLE;
            end
            default: begin
                cnt_n    = '0;
                estado_n = IDLE;
            end
        endcase
        if (inicio) begin
            cnt_n    = CNT_LAT;
            estado_n = (CNT_LAT == CNT_ONE) ? CARGA : CUENTA;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            estado   <= IDLE;
            cnt      <= '0;
            err_sinc <= 1'b0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
            if ((inicio && (estado == CUENTA)) || (pix_en && carga)) begin
                err_sinc <= 1'b1;
            end
        end
    end

    // A strobe landing on the load cycle loses: no shift and RGB holds.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            sr         <= 8'h00;
            RGB        <= COLOR_BG;
            video_on_d <= 1'b0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
        end else begin
            if (carga) begin
                sr <= DATO_ROM;
            end else if (pix_en) begin
                sr  <= {sr[6:0], 1'b0};
                RGB <= (video_on_d && sr[7]) ? COLOR_FG : COLOR_BG;
            end
            if (pix_en) begin
                video_on_d <= video_on;
                hsync_o    <= hsync_i;
                vsync_o    <= vsync_i;
            end
        end
    end

endmodule

// File: tb/tb_pixel_rom8x16.sv
// Directed bench for pixel_rom8x16 with LAT=2, FG=FF, BG=00.
module tb_pixel_rom8x16;

    logic       reloj    = 1'b0;
    logic       resetM   = 1'b0;
    logic       pix_en   = 1'b0;
    logic [9:0] Qh       = 10'd0;
    logic [9:0] Qv       = 10'd0;
    logic       video_on = 1'b0;
    logic       hsync_i  = 1'b1;
    logic       vsync_i  = 1'b1;
    logic [7:0] DATO_ROM = 8'h00;
    logic [7:0] RGB;
    logic       hsync_o;
    logic       vsync_o;
    logic       err_sinc;
    logic [1:0] estado_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] a5_exp [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic       prev_hs;
    logic       prev_vs;

    pixel_rom8x16 #(.LAT(2), .COLOR_FG(8'hFF), .COLOR_BG(8'h00)) dut (
        .reloj      (reloj),
        .resetM     (resetM),
        .pix_en     (pix_en),
        .Qh         (Qh),
        .Qv         (Qv),
        .video_on   (video_on),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .DATO_ROM   (DATO_ROM),
        .RGB        (RGB),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .err_sinc   (err_sinc),
        .estado_dbg (estado_dbg)
    );

    always #5 reloj = ~reloj;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        resetM = 1'b0;
        @(posedge reloj); #1;
        @(posedge reloj); #1;
        resetM = 1'b1;
    endtask

    // One strobe carrying qh, then gap-1 idle cycles; returns #1 after an edge.
    task automatic send_pix(input logic [9:0] qh, input int gap);
        Qh     = qh;
        pix_en = 1'b1;
        @(posedge reloj); #1;
        pix_en = 1'b0;
        repeat (gap - 1) begin
            @(posedge reloj); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while resetM is low
        @(posedge reloj); #1;
        chk8("rst_rgb", RGB, 8'h00);
        chk8("rst_hsync", {7'b0, hsync_o}, 8'h01);
        chk8("rst_vsync", {7'b0, vsync_o}, 8'h01);
        chk8("rst_err", {7'b0, err_sinc}, 8'h00);
        chk8("rst_state", {6'b0, estado_dbg}, 8'h00);
        @(posedge reloj); #1;
        resetM = 1'b1;

        // A5 glyph, strobe every 4 cycles then every 3 (LAT+1)
        DATO_ROM = 8'hA5;
        video_on = 1'b1;
        send_pix(10'd8, 4);
        chk8("a5_q8_bg", RGB, 8'h00);
        for (int j = 0; j < 8; j++) begin
            send_pix(10'(9 + j), 4);
            chk8($sformatf("a5_q%0d", 9 + j), RGB, a5_exp[j]);
        end
        for (int j = 0; j < 8; j++) begin
            send_pix(10'(17 + j), 3);
            chk8($sformatf("a5_gap3_q%0d", 17 + j), RGB, a5_exp[j]);
        end
        chk8("a5_gap3_err", {7'b0, err_sinc}, 8'h00);

        // video_on low; syncs delayed by one strobe
        do_reset();
        video_on = 1'b0;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
        for (int q = 8; q <= 16; q++) begin
            hsync_i = !((q == 11) || (q == 12));
            vsync_i = (q != 14);
            #1;
            chk8($sformatf("sync_pre_hs_q%0d", q), {7'b0, hsync_o}, {7'b0, prev_hs});
            send_pix(10'(q), 4);
            chk8($sformatf("vo0_rgb_q%0d", q), RGB, 8'h00);
            chk8($sformatf("hs_q%0d", q), {7'b0, hsync_o}, {7'b0, hsync_i});
            chk8($sformatf("vs_q%0d", q), {7'b0, vsync_o}, {7'b0, vsync_i});
            prev_hs = hsync_i;
            prev_vs = vsync_i;
        end
        hsync_i = 1'b1;
        vsync_i = 1'b1;

        // Reset pulse in the middle of a countdown abandons the load
        do_reset();
        video_on = 1'b1;
        DATO_ROM = 8'hFF;
        Qh       = 10'd8;
        pix_en   = 1'b1;
        @(posedge reloj); #1;
        pix_en = 1'b0;
        chk8("rstmid_state_cuenta", {6'b0, estado_dbg}, 8'h01);
        resetM = 1'b0;
        #1;
        chk8("rstmid_state_async", {6'b0, estado_dbg}, 8'h00);
        #1;
        resetM = 1'b1;
        repeat (3) begin
            @(posedge reloj); #1;
        end
        chk8("rstmid_state_after", {6'b0, estado_dbg}, 8'h00);
        for (int q = 9; q <= 16; q++) begin
            send_pix(10'(q), 4);
            chk8($sformatf("rstmid_q%0d", q), RGB, 8'h00);
        end
        send_pix(10'd17, 4);
        chk8("rstmid_q17", RGB, 8'hFF);

        // Strobe on the load cycle: load wins, RGB holds, error latches
        do_reset();
        video_on = 1'b1;
        DATO_ROM = 8'hFF;
        send_pix(10'd0, 4);
        for (int q = 1; q <= 7; q++) begin
            send_pix(10'(q), 4);
            chk8($sformatf("coll_fill_q%0d", q), RGB, 8'hFF);
        end
        send_pix(10'd8, 2);
        chk8("coll_q8", RGB, 8'hFF);
        chk8("coll_err_before", {7'b0, err_sinc}, 8'h00);
        DATO_ROM = 8'h00;
        send_pix(10'd9, 1);
        chk8("coll_hold_rgb", RGB, 8'hFF);
        chk8("coll_err", {7'b0, err_sinc}, 8'h01);
        send_pix(10'd10, 4);
        chk8("coll_after_load", RGB, 8'h00);

        // Strobe every cycle from a fresh reset
        do_reset();
        DATO_ROM = 8'hFF;
        send_pix(10'd0, 1);
        send_pix(10'd1, 1);
        chk8("fast_err_q1", {7'b0, err_sinc}, 8'h00);
        send_pix(10'd2, 1);
        chk8("fast_err_q2", {7'b0, err_sinc}, 8'h01);
        for (int q = 3; q <= 15; q++) begin
            send_pix(10'(q), 1);
        end
        repeat (20) begin
            @(posedge reloj); #1;
        end
        chk8("fast_err_sticky", {7'b0, err_sinc}, 8'h01);
        resetM = 1'b0;
        #1;
        chk8("fast_err_cleared", {7'b0, err_sinc}, 8'h00);
        @(posedge reloj); #1;
        resetM = 1'b1;

        // Line wrap 799 -> 0 is an ordinary cell start
        do_reset();
        video_on = 1'b1;
        DATO_ROM = 8'h80;
        for (int q = 796; q <= 799; q++) begin
            send_pix(10'(q), 4);
            chk8($sformatf("wrap_q%0d", q), RGB, 8'h00);
        end
        send_pix(10'd0, 4);
        chk8("wrap_q0", RGB, 8'h00);
        send_pix(10'd1, 4);
        chk8("wrap_q1", RGB, 8'hFF);
        for (int q = 2; q <= 8; q++) begin
            send_pix(10'(q), 4);
            chk8($sformatf("wrap_q%0d", q), RGB, 8'h00);
        end

        // Reset released mid-cell: background until the first loaded pixel
        do_reset();
        video_on = 1'b1;
        DATO_ROM = 8'hFF;
        for (int q = 3; q <= 8; q++) begin
            send_pix(10'(q), 4);
            chk8($sformatf("midcell_q%0d", q), RGB, 8'h00);
        end
        send_pix(10'd9, 4);
        chk8("midcell_q9", RGB, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_rom8x16.md
PIXEL_ROM8X16 -- requirements
Module: pixel_rom8x16

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the reloj cycles from a pix_en sample of Qh/Qv to valid font-ROM data (address register plus synchronous ROM).
REQ-002 The block SHALL have parameter COLOR_FG, default 8'hFF, giving the foreground RGB value.
REQ-003 The block SHALL have parameter COLOR_BG, default 8'h00, giving the background RGB value.
REQ-004 Port reloj: input, 1 bit; the single system clock, rising edge.
REQ-005 Port resetM: input, 1 bit; asynchronous, active-low reset.
REQ-006 Port pix_en: input, 1 bit; one-cycle pixel strobe, one per VGA pixel.
REQ-007 Port Qh: input, 10 bits; horizontal pixel counter, valid on pix_en cycles.
REQ-008 Port Qv: input, 10 bits; vertical pixel counter, valid on pix_en cycles.
REQ-009 Port video_on: input, 1 bit; visible-area flag aligned with Qh/Qv.
REQ-010 Port hsync_i: input, 1 bit; horizontal sync aligned with Qh/Qv.
REQ-011 Port vsync_i: input, 1 bit; vertical sync aligned with Qh/Qv.
REQ-012 Port DATO_ROM: input, 8 bits; 8x16 font-ROM row, bit 7 = leftmost column.
REQ-013 Port RGB: output, 8 bits; registered pixel colour.
REQ-014 Port hsync_o: output, 1 bit; hsync_i delayed to align with RGB.
REQ-015 Port vsync_o: output, 1 bit; vsync_i delayed to align with RGB.
REQ-016 Port err_sinc: output, 1 bit; sticky flag for a load/strobe timing collision.

Function
REQ-017 On a pix_en cycle with Qh[2:0]==3'b000, the block SHALL start a load countdown, cnt = LAT, independent of video_on.
REQ-018 The countdown SHALL decrement every reloj cycle; when it reaches zero, the 8-bit shift register SR SHALL load DATO_ROM and the countdown SHALL go idle.
REQ-019 States: IDLE (no countdown), CUENTA (cnt>0), CARGA (load cycle, one cycle) then IDLE; a new cell start seen during CUENTA SHALL restart cnt = LAT and raise err_sinc.
REQ-020 On every pix_en cycle not coinciding with CARGA: RGB <= (video_on_d && SR[7]) ? COLOR_FG : COLOR_BG, and SR <= {SR[6:0],1'b0}.
REQ-021 video_on_d, hsync_o and vsync_o SHALL be video_on, hsync_i and vsync_i registered on pix_en, giving exactly one pixel period of delay.
REQ-022 Net latency: the pixel for column Qh=8k+j SHALL appear on RGB at the pix_en where Qh=8k+j+1, for j=0..7.
REQ-023 If pix_en coincides with CARGA, the load SHALL win, no shift SHALL occur, RGB SHALL hold its value, and err_sinc SHALL be set.
REQ-024 Pixel strobes within a cell before the first load after reset SHALL output COLOR_BG, because SR is zero.
REQ-025 Qh wrap-around from the line end to 0 SHALL be treated as an ordinary cell start with no special case.
REQ-026 err_sinc SHALL clear only on reset.
REQ-027 pix_en spacing of LAT+1 or more reloj cycles SHALL never set err_sinc.

Reset
REQ-028 While resetM=0 (asynchronous), the block SHALL force RGB=COLOR_BG, hsync_o=1, vsync_o=1, SR=0, cnt=0, state IDLE, video_on_d=0 and err_sinc=0.
REQ-029 Deassertion of resetM SHALL take effect at the next reloj edge; a reset during CUENTA SHALL abandon the pending load.

Verification
REQ-030 pix_en every 4 cycles, LAT=2, Qh=8, video_on=1, DATO_ROM=8'hA5 -> RGB sequence FF,00,FF,00,00,FF,00,FF at Qh=9..16.
REQ-031 Same stimulus with video_on=0 -> RGB=00 for all 8 pixels; hsync_o/vsync_o follow the inputs one pixel late.
REQ-032 pix_en every cycle, LAT=2 -> err_sinc=1 after the first cell, and stays 1 until resetM=0.
REQ-033 resetM pulsed low mid-countdown with DATO_ROM=8'hFF -> no load occurs; RGB=00 until the next cell start plus 1 pixel.
REQ-034 Qh 799->0 wrap, DATO_ROM=8'h80 -> RGB=FF exactly at Qh=1 and 00 at Qh=2..8.
REQ-035 Reset released mid-cell at Qh=3 -> RGB=COLOR_BG until the pixel at Qh=9.
